// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide execute-stage sequencer.
package md_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } md_state_e;

  // WAIT cycles allowed before the operation is declared failed.
  localparam logic [5:0] TIMEOUT = 6'd40;

  localparam logic [4:0] RSTATUS_REG = 5'd30;
  localparam logic [4:0] MUL_EXC     = 5'd4;
  localparam logic [4:0] DIV_EXC     = 5'd5;

  // Start opcodes (only legal for one cycle) and result-read opcodes.
  // The read opcodes share bits [2:0] with the start opcodes so the ALU
  // output mux picks the multdiv result without restarting the unit.
  localparam logic [4:0] OP_MUL    = 5'd6;
  localparam logic [4:0] OP_DIV    = 5'd7;
  localparam logic [4:0] OP_MUL_RD = 5'd14;
  localparam logic [4:0] OP_DIV_RD = 5'd15;

  // Zero-extended exception code written to $rstatus.
  function automatic logic [31:0] exc_status(input logic is_div);
    logic [31:0] code;
    if (is_div) begin
      code = {27'd0, DIV_EXC};
    end else begin
      code = {27'd0, MUL_EXC};
    end
    return code;
  endfunction

  // Override opcode for the start cycle or the result-read phase.
  function automatic logic [4:0] ovr_opcode(input logic is_div, input logic read_phase);
    logic [4:0] op;
    case ({read_phase, is_div})
      2'b00:   op = OP_MUL;
      2'b01:   op = OP_DIV;
      2'b10:   op = OP_MUL_RD;
      2'b11:   op = OP_DIV_RD;
      default: op = OP_MUL;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/md_timeout_ctr.sv
// Saturating 6-bit WAIT-cycle counter; hit flags the last allowed WAIT cycle.
module md_timeout_ctr
  import md_pkg::*;
#(
  parameter logic [5:0] LIMIT = TIMEOUT
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic hit
);

  logic [5:0] count_r;

  // Count WAIT cycles, saturating at 63 so a stuck count never wraps into a false hit.
  always_ff @(posedge clock) begin
    if (reset) begin
      count_r <= 6'd0;
    end else if (clear) begin
      count_r <= 6'd0;
    end else if (enable && (count_r != 6'h3F)) begin
      count_r <= count_r + 6'd1;
    end else begin
      count_r <= count_r;
    end
  end

  assign hit = (count_r == (LIMIT - 6'd1));

endmodule

// File: rtl/md_sequencer.sv
// Execute-stage sequencer: freezes the pipeline around one mult/div,
// issues a single start, waits for the result or a timeout and produces
// exactly one writeback (result to rd or exception code to r30).
module md_sequencer
  import md_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        op_valid,
  input  logic        op_is_div,
  input  logic [4:0]  op_rd,
  input  logic        flush,
  input  logic [31:0] md_result,
  input  logic        md_rdy,
  input  logic        md_exc,
  output logic        alu_ovr_en,
  output logic [4:0]  alu_ovr_op,
  output logic        stall,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        wb_exc
);

  md_state_e   state_r;
  md_state_e   state_s;
  logic        is_div_r;
  logic [4:0]  rd_r;
  logic        hit_s;
  logic        cur_div_s;
  logic        exc_s;

  md_timeout_ctr u_timeout (
    .clock  (clock),
    .reset  (reset),
    .clear  (state_r == ST_ISSUE),
    .enable (state_r == ST_WAIT),
    .hit    (hit_s)
  );

  // While still in IDLE the latched kind is not valid yet, so use the live input.
  assign cur_div_s = (state_r == ST_IDLE) ? op_is_div : is_div_r;
  // A ready result beats a same-cycle timeout; without ready only timeout can exit.
  assign exc_s     = md_rdy ? md_exc : 1'b1;

  // Next-state selection; flush kills an operation before it completes.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (op_valid && !flush) begin
          state_s = ST_ISSUE;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (flush) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (flush) begin
          state_s = ST_IDLE;
        end else if (md_rdy || hit_s) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_WAIT;
        end
      end
      ST_DONE: state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // Pipeline freeze: raised the cycle the op appears in X, dropped in DONE.
  always_comb begin
    stall = 1'b0;
    case (state_r)
      ST_IDLE:  stall = op_valid && !flush;
      ST_ISSUE: stall = 1'b1;
      ST_WAIT:  stall = 1'b1;
      ST_DONE:  stall = 1'b0;
      default:  stall = 1'b0;
    endcase
  end

  // State register and operation context latched on leaving IDLE.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r  <= ST_IDLE;
      is_div_r <= 1'b0;
      rd_r     <= 5'd0;
    end else begin
      state_r <= state_s;
      if ((state_r == ST_IDLE) && (state_s == ST_ISSUE)) begin
        is_div_r <= op_is_div;
        rd_r     <= op_rd;
      end else begin
        is_div_r <= is_div_r;
        rd_r     <= rd_r;
      end
    end
  end

  // Registered ALU override and writeback, computed from the state being entered.
  always_ff @(posedge clock) begin
    if (reset) begin
      alu_ovr_en <= 1'b0;
      alu_ovr_op <= 5'd0;
      wb_valid   <= 1'b0;
      wb_rd      <= 5'd0;
      wb_data    <= 32'd0;
      wb_exc     <= 1'b0;
    end else begin
      alu_ovr_en <= (state_s == ST_ISSUE) || (state_s == ST_WAIT);
      if (state_s == ST_ISSUE) begin
        alu_ovr_op <= ovr_opcode(cur_div_s, 1'b0);
      end else if (state_s == ST_WAIT) begin
        alu_ovr_op <= ovr_opcode(is_div_r, 1'b1);
      end else begin
        alu_ovr_op <= 5'd0;
      end

      if ((state_r == ST_WAIT) && (state_s == ST_DONE)) begin
        // rd = 0 suppresses a normal writeback; the status write still happens.
        wb_valid <= exc_s || (rd_r != 5'd0);
        wb_rd    <= exc_s ? RSTATUS_REG : rd_r;
        wb_data  <= exc_s ? exc_status(is_div_r) : md_result;
        wb_exc   <= exc_s;
      end else begin
        wb_valid <= 1'b0;
        wb_rd    <= 5'd0;
        wb_data  <= 32'd0;
        wb_exc   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_md_sequencer.sv
// Directed bench for md_sequencer with a cycle-offset reference model.
module tb_md_sequencer;

  localparam int TO = 40;

  logic        clock;
  logic        reset;
  logic        op_valid;
  logic        op_is_div;
  logic [4:0]  op_rd;
  logic        flush;
  logic [31:0] md_result;
  logic        md_rdy;
  logic        md_exc;
  logic        alu_ovr_en;
  logic [4:0]  alu_ovr_op;
  logic        stall;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        wb_exc;

  int vectors = 0;
  int miscompares = 0;

  md_sequencer dut (
    .clock      (clock),
    .reset      (reset),
    .op_valid   (op_valid),
    .op_is_div  (op_is_div),
    .op_rd      (op_rd),
    .flush      (flush),
    .md_result  (md_result),
    .md_rdy     (md_rdy),
    .md_exc     (md_exc),
    .alu_ovr_en (alu_ovr_en),
    .alu_ovr_op (alu_ovr_op),
    .stall      (stall),
    .wb_valid   (wb_valid),
    .wb_rd      (wb_rd),
    .wb_data    (wb_data),
    .wb_exc     (wb_exc)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: an accepted op is tracked by its age in cycles
  // (age 1 = start cycle, age >= 2 = waiting, WAIT number = age-1).
  bit          m_init = 1'b0;
  bit          m_busy = 1'b0;
  bit          m_done = 1'b0;
  int          m_age  = 0;
  bit          m_div  = 1'b0;
  logic [4:0]  m_rd   = 5'd0;
  bit          m_exc  = 1'b0;
  logic [31:0] m_res  = 32'd0;

  always @(posedge clock) begin
    if (reset) begin
      m_init = 1'b1;
      m_busy = 1'b0;
      m_done = 1'b0;
    end else if (!m_init) begin
      m_busy = 1'b0;
    end else if (m_done) begin
      m_done = 1'b0;
    end else if (m_busy) begin
      if (flush) begin
        m_busy = 1'b0;
      end else if (m_age >= 2 && (md_rdy || (m_age - 1) == TO)) begin
        m_exc  = md_rdy ? md_exc : 1'b1;
        m_res  = md_result;
        m_done = 1'b1;
        m_busy = 1'b0;
      end else begin
        m_age = m_age + 1;
      end
    end else if (op_valid && !flush) begin
      m_busy = 1'b1;
      m_age  = 1;
      m_div  = op_is_div;
      m_rd   = op_rd;
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clock) begin
    logic        e_stall;
    logic [4:0]  e_op;
    logic        e_wbv;
    if (m_init) begin
      e_stall = m_busy || (!m_done && op_valid && !flush);
      if (!m_busy)         e_op = 5'd0;
      else if (m_age == 1) e_op = m_div ? 5'd7 : 5'd6;
      else                 e_op = m_div ? 5'd15 : 5'd14;
      e_wbv = m_done && (m_exc || m_rd != 5'd0);
      check("stall", 32'(stall), 32'(e_stall));
      check("alu_ovr_en", 32'(alu_ovr_en), 32'(m_busy));
      check("alu_ovr_op", 32'(alu_ovr_op), 32'(e_op));
      check("wb_valid", 32'(wb_valid), 32'(e_wbv));
      if (e_wbv) begin
        check("wb_rd", 32'(wb_rd), m_exc ? 32'd30 : 32'(m_rd));
        check("wb_data", wb_data, m_exc ? (m_div ? 32'd5 : 32'd4) : m_res);
        check("wb_exc", 32'(wb_exc), 32'(m_exc));
      end
    end
  end

  // One operation held in X for cycles 0..last; reports what it observed.
  task automatic run_op(input logic div, input logic [4:0] rd, input int rdy_at,
                        input logic exc, input logic [31:0] res, input int flush_at,
                        input int rst_at, input int last,
                        output int issues, output int wb_cyc, output int stall_n,
                        output logic [4:0] wr, output logic [31:0] wd);
    issues = 0; wb_cyc = -1; stall_n = 0; wr = 5'd0; wd = 32'd0;
    for (int c = 0; c <= last; c++) begin
      op_valid  = 1'b1;
      op_is_div = div;
      op_rd     = rd;
      md_result = res;
      flush     = (c == flush_at);
      reset     = (c == rst_at);
      md_rdy    = (c == rdy_at);
      md_exc    = exc && (c == rdy_at);
      @(negedge clock);
      if (alu_ovr_op == 5'd6 || alu_ovr_op == 5'd7) issues++;
      if (stall) stall_n++;
      if (wb_valid) begin
        wb_cyc = c;
        wr     = wb_rd;
        wd     = wb_data;
      end
      @(posedge clock); #1;
    end
  endtask

  task automatic quiet_inputs();
    op_valid = 1'b0; op_is_div = 1'b0; op_rd = 5'd0; flush = 1'b0;
    md_rdy = 1'b0; md_exc = 1'b0; md_result = 32'd0; reset = 1'b0;
  endtask

  task automatic idle(input int n);
    quiet_inputs();
    for (int i = 0; i < n; i++) begin
      @(posedge clock); #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int iss, wc, sn;
    logic [4:0]  wr;
    logic [31:0] wd;
    quiet_inputs();
    reset = 1'b1;
    @(posedge clock); #1;
    @(negedge clock);
    check("rst_wb_valid", 32'(wb_valid), 32'd0);
    check("rst_wb_data", wb_data, 32'd0);
    check("rst_ovr_en", 32'(alu_ovr_en), 32'd0);
    check("rst_ovr_op", 32'(alu_ovr_op), 32'd0);
    @(posedge clock); #1;
    reset = 1'b0;
    idle(1);

    // mult, ready at cycle 10
    run_op(1'b0, 5'd3, 10, 1'b0, 32'h0000_0C00, -1, -1, 11, iss, wc, sn, wr, wd);
    check("t1_issues", 32'(iss), 32'd1);
    check("t1_wb_cycle", 32'(wc), 32'd11);
    check("t1_stall_cycles", 32'(sn), 32'd11);
    check("t1_wb_rd", 32'(wr), 32'd3);
    check("t1_wb_data", wd, 32'h0000_0C00);
    idle(1);

    // div with exception
    run_op(1'b1, 5'd8, 5, 1'b1, 32'h0000_1234, -1, -1, 6, iss, wc, sn, wr, wd);
    check("t2_wb_cycle", 32'(wc), 32'd6);
    check("t2_wb_rd", 32'(wr), 32'd30);
    check("t2_wb_data", wd, 32'd5);
    idle(1);

    // mult timeout: 40 WAIT cycles (2..41), DONE at 42
    run_op(1'b0, 5'd4, -1, 1'b0, 32'h0000_AAAA, -1, -1, 42, iss, wc, sn, wr, wd);
    check("t3_wb_cycle", 32'(wc), 32'd42);
    check("t3_wb_rd", 32'(wr), 32'd30);
    check("t3_wb_data", wd, 32'd4);
    check("t3_stall_cycles", 32'(sn), 32'd42);
    idle(1);

    // ready on the timeout cycle: ready wins
    run_op(1'b0, 5'd9, 41, 1'b0, 32'hDEAD_BEEF, -1, -1, 42, iss, wc, sn, wr, wd);
    check("t4_wb_cycle", 32'(wc), 32'd42);
    check("t4_wb_rd", 32'(wr), 32'd9);
    check("t4_wb_data", wd, 32'hDEAD_BEEF);
    idle(1);

    // minimum latency: ready in first WAIT cycle
    run_op(1'b1, 5'd12, 2, 1'b0, 32'h0000_0007, -1, -1, 3, iss, wc, sn, wr, wd);
    check("t5_wb_cycle", 32'(wc), 32'd3);
    check("t5_wb_rd", 32'(wr), 32'd12);
    idle(1);

    // div flushed in third WAIT cycle, then a clean mult
    run_op(1'b1, 5'd6, -1, 1'b0, 32'd0, 4, -1, 4, iss, wc, sn, wr, wd);
    check("t6_no_wb", 32'(wc), 32'hFFFF_FFFF);
    quiet_inputs();
    @(negedge clock);
    check("t6_stall_after_flush", 32'(stall), 32'd0);
    check("t6_wb_after_flush", 32'(wb_valid), 32'd0);
    @(posedge clock); #1;
    run_op(1'b0, 5'd7, 3, 1'b0, 32'h0000_0055, -1, -1, 4, iss, wc, sn, wr, wd);
    check("t6_issues", 32'(iss), 32'd1);
    check("t6_wb_cycle", 32'(wc), 32'd4);
    check("t6_wb_data", wd, 32'h0000_0055);
    idle(1);

    // flush in the start cycle
    run_op(1'b0, 5'd10, -1, 1'b0, 32'd0, 1, -1, 1, iss, wc, sn, wr, wd);
    check("t7_issues", 32'(iss), 32'd1);
    check("t7_no_wb", 32'(wc), 32'hFFFF_FFFF);
    idle(2);

    // reset in WAIT with ready high
    run_op(1'b0, 5'd11, 3, 1'b0, 32'h0000_0099, -1, 3, 3, iss, wc, sn, wr, wd);
    check("t8_no_wb", 32'(wc), 32'hFFFF_FFFF);
    quiet_inputs();
    @(negedge clock);
    check("t8_wb_valid", 32'(wb_valid), 32'd0);
    check("t8_wb_rd", 32'(wb_rd), 32'd0);
    check("t8_wb_data", wb_data, 32'd0);
    check("t8_wb_exc", 32'(wb_exc), 32'd0);
    check("t8_ovr_en", 32'(alu_ovr_en), 32'd0);
    check("t8_ovr_op", 32'(alu_ovr_op), 32'd0);
    check("t8_stall", 32'(stall), 32'd0);
    @(posedge clock); #1;

    // back-to-back mults, rd = 0 then rd = 5
    run_op(1'b0, 5'd0, 3, 1'b0, 32'h0000_0111, -1, -1, 4, iss, wc, sn, wr, wd);
    check("t9_rd0_no_wb", 32'(wc), 32'hFFFF_FFFF);
    run_op(1'b0, 5'd5, 3, 1'b0, 32'h0000_0222, -1, -1, 4, iss, wc, sn, wr, wd);
    check("t9_wb_cycle", 32'(wc), 32'd4);
    check("t9_wb_rd", 32'(wr), 32'd5);
    check("t9_wb_data", wd, 32'h0000_0222);
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/md_sequencer.md
# md_sequencer

Execute-stage sequencer for multiply/divide in the pipelined processor. It sits beside the ALU in X. When a mult/div instruction reaches X, it freezes the pipeline and issues exactly one start to the ALU's multdiv unit. It then holds the ALU in result-read mode until `data_resultRDY` or a timeout, and hands one writeback to the X/M latch: either the product/quotient to rd, or an exception code to $rstatus (r30).

## Interface
- `TIMEOUT`, 40: WAIT cycles allowed before forcing an exception.
- `RSTATUS_REG`, 30: exception destination register.
- `MUL_EXC`, 4: exception code for mult.
- `DIV_EXC`, 5: exception code for div.

Ports:
- `clock` in 1: single clock. All state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `op_valid` in 1: the instruction in X is mult or div.
- `op_is_div` in 1: 1 = div, 0 = mult. Valid with `op_valid`.
- `op_rd` in 5: destination register of the X instruction.
- `flush` in 1: kill the X instruction (taken branch / jump).
- `md_result` in 32: ALU `data_result`.
- `md_rdy` in 1: ALU `data_resultRDY`.
- `md_exc` in 1: ALU `data_exception`.
- `alu_ovr_en` out 1: X stage uses `alu_ovr_op` instead of the decoded opcode.
- `alu_ovr_op` out 5: opcode driven to the ALU while overriding.
- `stall` out 1: freeze PC, F/D and D/X latches. Combinational.
- `wb_valid` out 1: one-cycle writeback qualifier into X/M.
- `wb_rd` out 5: writeback destination.
- `wb_data` out 32: writeback value.
- `wb_exc` out 1: writeback is an exception status write.

## Operation
- States:
  - IDLE: no op in progress.
  - ISSUE: start the multdiv.
  - WAIT: hold result-read, count toward timeout.
  - DONE: present writeback.
- Latched at IDLE exit: `op_is_div`, `op_rd`.
- Transitions:
  - IDLE→ISSUE on `op_valid & ~flush`.
  - ISSUE→WAIT always.
  - WAIT→DONE on `md_rdy`, or when the counter reaches `TIMEOUT-1`.
  - DONE→IDLE always.
- `flush` in ISSUE or WAIT: go to IDLE. No writeback. The multdiv result is discarded.
- Override opcode:
  - ISSUE: 5'd6 (mult) or 5'd7 (div). This is the only cycle `ctrl_MULT`/`ctrl_DIV` assert.
  - WAIT: 5'd14 / 5'd15. Bits [2:0] select the multdiv result at the ALU output mux but do not match 6/7, so the unit is not restarted.
  - `alu_ovr_en` = 1 in ISSUE and WAIT only.
- Result capture: on the WAIT cycle the exit condition holds, register `md_result`, `md_exc` and a timeout flag.
- DONE outputs:
  - Normal: `wb_rd` = latched rd, `wb_data` = captured result, `wb_exc` = 0.
  - `md_exc` or timeout: `wb_rd` = `RSTATUS_REG`, `wb_data` = `DIV_EXC` or `MUL_EXC` (zero-extended), `wb_exc` = 1.
  - Both `md_rdy` and timeout in the same cycle: `md_rdy` wins (normal result unless `md_exc`).
- `op_rd` = 0: no writeback (`wb_valid` stays 0 in DONE). The exception path still writes r30.
- `op_valid` is ignored in DONE; that instruction is the completing one. A following mult/div is picked up in IDLE the next cycle.

## Timing
- Reset: state IDLE, counter 0. All registered outputs 0: `wb_valid`, `wb_rd`, `wb_data`, `wb_exc`, `alu_ovr_en`, `alu_ovr_op`.
- `stall` = (IDLE & `op_valid` & ~`flush`) | ISSUE | WAIT. It rises in the same cycle the op enters X and is low in DONE, so the pipeline advances exactly when `wb_valid` = 1.
- Counter: 6-bit. Cleared in ISSUE, increments each WAIT cycle. At 63 it saturates (no wrap).
- Latency, op in X at cycle 0, `md_rdy` seen at cycle k ≥ 2: DONE at k+1. The minimum is 4 cycles: `md_rdy` sampled in the first WAIT cycle (cycle 2) gives DONE at cycle 3.
- Back-to-back mult/div: second op in X at cycle k+2. DONE→IDLE costs one cycle.
- Reset mid-operation: immediate return to IDLE next edge. No writeback.

## Structure
- Shared package `md_pkg`:
  - state encoding (IDLE = 0, ISSUE = 1, WAIT = 2, DONE = 3)
  - opcode constants `OP_MUL = 6`, `OP_DIV = 7`, `OP_MUL_RD = 14`, `OP_DIV_RD = 15`
  - `RSTATUS_REG`, `MUL_EXC`, `DIV_EXC`
- Natural sub-module: `md_timeout_ctr`, a 6-bit saturating counter with clear/enable and `hit` = (count == TIMEOUT-1).

## Test plan
- mult, `md_rdy` at cycle 10, `md_result` = 32'h0000_0C00, rd = 3:
  - `stall` high cycles 0–10.
  - `alu_ovr_op` = 6 at cycle 1, then 14 through cycle 10.
  - DONE at cycle 11: `wb_valid` = 1, `wb_rd` = 3, `wb_data` = 32'h0000_0C00.
- div, `md_rdy` with `md_exc` = 1 → DONE: `wb_rd` = 30, `wb_data` = 5, `wb_exc` = 1.
- mult, `md_rdy` never asserts → DONE after exactly 40 WAIT cycles: `wb_rd` = 30, `wb_data` = 4.
- div, `flush` asserted in the third WAIT cycle → IDLE next cycle, `stall` low, no `wb_valid` pulse. A new mult issues cleanly (`alu_ovr_op` = 6 exactly once).
- `reset` asserted in WAIT while `md_rdy` = 1 → IDLE, all outputs 0. Two back-to-back mults with rd = 0 then rd = 5 → second DONE writes rd 5 only.
